// File: rtl/pe_feeder.sv
// Tile feeder for a 4x4 PE array: buffers up to DEPTH k-steps of row data and
// column weights, then replays a tile with lane i delayed by i cycles.
module pe_feeder #(
   parameter int DW        = 32,
   parameter int DEPTH     = 16,
   parameter int DRAIN_CYC = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [4*DW-1:0]            wr_data,
   input  logic [4*DW-1:0]            wr_weight,
   input  logic                       start,
   input  logic [$clog2(DEPTH):0]     len,
   output logic                       busy,
   output logic                       done,
   output logic [DW-1:0]              data0_out,
   output logic [DW-1:0]              data1_out,
   output logic [DW-1:0]              data2_out,
   output logic [DW-1:0]              data3_out,
   output logic [DW-1:0]              weight0_out,
   output logic [DW-1:0]              weight1_out,
   output logic [DW-1:0]              weight2_out,
   output logic [DW-1:0]              weight3_out,
   output logic                       feed_valid
);

   localparam int AW     = $clog2(DEPTH);
   localparam int LW     = AW + 1;
   localparam int CW_RAW = $clog2(DEPTH + DRAIN_CYC + 4);
   localparam int CW     = (CW_RAW > LW) ? CW_RAW : LW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_DRAIN
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [LW-1:0]   len_q;
   logic            busy_q;
   logic            done_q;
   logic            feed_valid_q;

   logic [4*DW-1:0] mem_data_q   [DEPTH];
   logic [4*DW-1:0] mem_weight_q [DEPTH];

   logic            start_acc;
   logic [LW-1:0]   len_eff;
   logic [CW-1:0]   len_cw;
   logic [CW-1:0]   rd_idx;
   logic [AW-1:0]   rd_addr;
   logic            rd_live;
   logic            bypass;
   logic [4*DW-1:0] rd_data;
   logic [4*DW-1:0] rd_weight;

   assign start_acc = start && (state_q == S_IDLE);
   assign len_eff   = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
   assign len_cw    = CW'(len_q);

   // cnt_q is the current t, so the edge closing cycle t fetches k-step t+1.
   assign rd_idx  = start_acc ? '0 : cnt_q + CW'(1);
   assign rd_addr = rd_idx[AW-1:0];
   assign rd_live = start_acc ? (len_eff != '0)
                              : ((state_q == S_FEED) && (rd_idx < len_cw));
   assign bypass  = wr_en && !busy_q && (wr_addr == rd_addr);

   // Forward a same-edge write so a tile sees data written with its start.
   always_comb begin
      rd_data   = '0;
      rd_weight = '0;
      if (rd_live) begin
         if (bypass) begin
            rd_data   = wr_data;
            rd_weight = wr_weight;
         end else begin
            rd_data   = mem_data_q[rd_addr];
            rd_weight = mem_weight_q[rd_addr];
         end
      end
   end

   // NOTE: the buffer has no reset; contents survive reset and are only ever
   // read after software has written them, so clearing them would buy nothing.
   always_ff @(posedge clk) begin
      if (wr_en && !busy_q) begin
         mem_data_q[wr_addr]   <= wr_data;
         mem_weight_q[wr_addr] <= wr_weight;
      end
   end

   // NOTE: every register here uses <= so all reads see pre-edge values;
   // a blocking = would let later lines observe half-updated state.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         len_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         feed_valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (len_eff == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q      <= S_FEED;
                     len_q        <= len_eff;
                     cnt_q        <= '0;
                     busy_q       <= 1'b1;
                     feed_valid_q <= 1'b1;
                  end
               end
            end
            S_FEED: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == len_cw + CW'(2)) begin
                  feed_valid_q <= 1'b0;
                  if (DRAIN_CYC == 0) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == len_cw + CW'(2) + CW'(DRAIN_CYC)) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Lane i passes through i skew stages before its output register.
   for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [DW-1:0] d_tap;
      logic [DW-1:0] w_tap;
      logic [DW-1:0] d_out_q;
      logic [DW-1:0] w_out_q;

      if (i == 0) begin : g_direct
         assign d_tap = rd_data[DW-1:0];
         assign w_tap = rd_weight[DW-1:0];
      end else begin : g_skew
         logic [DW-1:0] d_sk_q [i];
         logic [DW-1:0] w_sk_q [i];

         always_ff @(posedge clk) begin
            if (rst_n) begin
               for (int k = 0; k < i; k++) begin
                  d_sk_q[k] <= '0;
                  w_sk_q[k] <= '0;
               end
            end else begin
               d_sk_q[0] <= rd_data[i*DW +: DW];
               w_sk_q[0] <= rd_weight[i*DW +: DW];
               for (int k = 1; k < i; k++) begin
                  d_sk_q[k] <= d_sk_q[k-1];
                  w_sk_q[k] <= w_sk_q[k-1];
               end
            end
         end

         assign d_tap = d_sk_q[i-1];
         assign w_tap = w_sk_q[i-1];
      end

      always_ff @(posedge clk) begin
         if (rst_n) begin
            d_out_q <= '0;
            w_out_q <= '0;
         end else begin
            d_out_q <= d_tap;
            w_out_q <= w_tap;
         end
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign feed_valid  = feed_valid_q;
   assign data0_out   = g_lane[0].d_out_q;
   assign data1_out   = g_lane[1].d_out_q;
   assign data2_out   = g_lane[2].d_out_q;
   assign data3_out   = g_lane[3].d_out_q;
   assign weight0_out = g_lane[0].w_out_q;
   assign weight1_out = g_lane[1].w_out_q;
   assign weight2_out = g_lane[2].w_out_q;
   assign weight3_out = g_lane[3].w_out_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: window-based tile model checked every cycle, plus
// directed tiles with hand-computed expectations.
module tb_pe_feeder;

   localparam int DW        = 32;
   localparam int DEPTH     = 16;
   localparam int DRAIN_CYC = 6;
   localparam int AW        = 4;
   localparam int LW        = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [4*DW-1:0]   wr_data;
   logic [4*DW-1:0]   wr_weight;
   logic              start;
   logic [LW-1:0]     len;
   logic              busy;
   logic              done;
   logic              feed_valid;
   logic [DW-1:0]     d0, d1, d2, d3, w0, w1, w2, w3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pe_feeder #(.DW(DW), .DEPTH(DEPTH), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_weight(wr_weight),
      .start(start), .len(len),
      .busy(busy), .done(done),
      .data0_out(d0), .data1_out(d1), .data2_out(d2), .data3_out(d3),
      .weight0_out(w0), .weight1_out(w1), .weight2_out(w2), .weight3_out(w3),
      .feed_valid(feed_valid)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, req);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [4*DW-1:0] m_data [DEPTH];
   logic [4*DW-1:0] m_wgt  [DEPTH];
   logic [4*DW-1:0] s_data [DEPTH];
   logic [4*DW-1:0] s_wgt  [DEPTH];
   bit  tile_active = 1'b0;
   int  t0 = 0, tlen = 0, done_cyc = -1, cyc = 0;
   bit  mon_en = 1'b0;
   bit  bprev;
   logic [DW-1:0] ed [4];
   logic [DW-1:0] ew [4];
   logic [DW-1:0] ad [4];
   logic [DW-1:0] aw [4];

   function automatic bit m_busy(int c);
      return tile_active && c >= t0 && c <= t0 + tlen + 2 + DRAIN_CYC;
   endfunction

   // cyc counts rising edges; cycle c is the interval that follows edge c.
   always @(posedge clk) begin
      cyc++;
      bprev = m_busy(cyc - 1);
      if (wr_en && !bprev) begin
         m_data[wr_addr] = wr_data;
         m_wgt[wr_addr]  = wr_weight;
      end
      if (rst_n) begin
         tile_active = 1'b0;
         done_cyc    = -1;
      end else if (start && !bprev) begin
         if (len == 0) begin
            done_cyc = cyc;
         end else begin
            tile_active = 1'b1;
            t0          = cyc;
            tlen        = (int'(len) > DEPTH) ? DEPTH : int'(len);
            done_cyc    = cyc + tlen + 3 + DRAIN_CYC;
            s_data      = m_data;
            s_wgt       = m_wgt;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         ad = '{d0, d1, d2, d3};
         aw = '{w0, w1, w2, w3};
         for (int i = 0; i < 4; i++) begin
            int k;
            ed[i] = '0;
            ew[i] = '0;
            k = cyc - t0 - i;
            if (tile_active && k >= 0 && k < tlen) begin
               ed[i] = s_data[k][i*DW +: DW];
               ew[i] = s_wgt[k][i*DW +: DW];
            end
            check($sformatf("data%0d", i), ad[i], ed[i]);
            check($sformatf("weight%0d", i), aw[i], ew[i]);
         end
         check("busy", busy, m_busy(cyc));
         check("done", done, cyc == done_cyc);
         check("feed_valid", feed_valid, tile_active && cyc >= t0 && cyc <= t0 + tlen + 2);
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [4*DW-1:0] pack(input int base);
      logic [4*DW-1:0] v;
      for (int i = 0; i < 4; i++) v[i*DW +: DW] = DW'(base + i);
      return v;
   endfunction

   function automatic logic [4*DW-1:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic write_entry(input int a, input logic [4*DW-1:0] d, input logic [4*DW-1:0] w);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_weight = w;
      @(negedge clk); #1;
      wr_en = 1'b0;
   endtask

   // Samples from t=t_from onward; returns first done t (-1 if none) and
   // last t with feed_valid high.
   task automatic follow(input int t_from, input int t_max, input bit stop_at_done,
                         output int t_done, output int fv_last, output int n_done);
      t_done = -1; fv_last = -1; n_done = 0;
      for (int t = t_from; t <= t_max; t++) begin
         @(negedge clk);
         if (feed_valid === 1'b1) fv_last = t;
         if (done === 1'b1) begin
            n_done++;
            if (t_done < 0) t_done = t;
            if (stop_at_done) return;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_done, fv_last, n_done, c1, c2;
      rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_weight = '0;
      start = 1'b0; len = '0;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_data0", d0, 0);
      #1 rst_n = 1'b0;

      for (int k = 0; k < DEPTH; k++) write_entry(k, rnd128(), rnd128());
      for (int k = 0; k < 4; k++) write_entry(k, pack(16*k), pack(256 + 16*k));

      // Basic 4-step tile
      start = 1'b1; len = 4;
      @(negedge clk);                        // t=0
      check("t0_data0", d0, 32'h00);
      check("t0_weight0", w0, 32'h100);
      check("t0_data1", d1, 32'h00);
      #1 start = 1'b0;
      @(negedge clk);                        // t=1
      check("t1_data0", d0, 32'h10);
      check("t1_data1", d1, 32'h01);
      repeat (2) @(negedge clk);             // t=3
      check("t3_data3", d3, 32'h03);
      check("t3_weight3", w3, 32'h103);
      repeat (3) @(negedge clk);             // t=6
      check("t6_data3", d3, 32'h33);
      check("t6_fv", feed_valid, 1);
      @(negedge clk);                        // t=7
      check("t7_fv", feed_valid, 0);
      check("t7_zero", d0 | d1 | d2 | d3 | w0 | w1 | w2 | w3, 0);
      follow(8, 40, 1'b1, t_done, fv_last, n_done);
      check("len4_done_t", t_done, 13);
      check("len4_busy_at_done", busy, 0);

      // Zero-length tile
      #1 start = 1'b1; len = 0;
      @(negedge clk);
      check("len0_done", done, 1);
      check("len0_busy", busy, 0);
      check("len0_data0", d0, 0);
      #1 start = 1'b0;
      @(negedge clk);
      check("len0_done_after", done, 0);
      check("len0_busy_after", busy, 0);

      // Clamped tile
      #1 start = 1'b1; len = 20;
      @(negedge clk);
      #1 start = 1'b0;
      follow(1, 60, 1'b1, t_done, fv_last, n_done);
      check("len20_done_t", t_done, 25);
      check("len20_fv_last", fv_last, 18);

      // Reset mid-tile, then a new tile right after release
      #1 start = 1'b1; len = 8;
      @(negedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);             // t=5
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_fv", feed_valid, 0);
      check("rst_lanes", d0 | d1 | d2 | d3 | w0 | w1 | w2 | w3, 0);
      #1 rst_n = 1'b0; start = 1'b1; len = 2;
      @(negedge clk);
      #1 start = 1'b0;
      follow(1, 40, 1'b1, t_done, fv_last, n_done);
      check("post_rst_done_t", t_done, 11);

      // Dropped write and ignored start during busy
      #1 write_entry(0, pack(32'h5555), pack(32'h6666));
      start = 1'b1; len = 2;
      @(negedge clk);
      #1 start = 1'b0;
      @(negedge clk);                        // t=1
      #1 wr_en = 1'b1; wr_addr = '0; wr_data = pack(32'hAAAA); wr_weight = pack(32'hBBBB);
      start = 1'b1; len = 3;
      @(negedge clk);
      #1 wr_en = 1'b0; start = 1'b0;
      follow(3, 40, 1'b0, t_done, fv_last, n_done);
      check("busy_start_n_done", n_done, 1);
      check("busy_start_done_t", t_done, 11);
      #1 start = 1'b1; len = 1;
      @(negedge clk);
      check("kept_data0", d0, 32'h5555);
      check("kept_weight0", w0, 32'h6666);
      #1 start = 1'b0;
      follow(1, 40, 1'b1, t_done, fv_last, n_done);

      // Back-to-back: start in the done cycle of a len=1 tile
      #1 start = 1'b1; len = 1;
      @(negedge clk);
      #1 start = 1'b0;
      follow(1, 40, 1'b1, t_done, fv_last, n_done);
      c1 = cyc;
      #1 start = 1'b1; len = 1;
      @(negedge clk);
      check("b2b_busy_t0", busy, 1);
      check("b2b_data0_t0", d0, 32'h5555);
      #1 start = 1'b0;
      follow(1, 40, 1'b1, t_done, fv_last, n_done);
      c2 = cyc;
      check("b2b_cycles_between_dones", c2 - c1 - 1, 10);

      // Randomized traffic; the per-cycle model does the checking
      for (int n = 0; n < 3000; n++) begin
         #1;
         wr_en     = ($urandom_range(0, 3) == 0);
         wr_addr   = AW'($urandom_range(0, DEPTH - 1));
         wr_data   = rnd128();
         wr_weight = rnd128();
         start     = ($urandom_range(0, 9) == 0);
         len       = LW'($urandom_range(0, 31));
         rst_n     = ($urandom_range(0, 149) == 0);
         @(negedge clk);
      end
      #1 wr_en = 1'b0; start = 1'b0; rst_n = 1'b0;
      repeat (40) @(negedge clk);
      check("quiet_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameter DW, default 32, meaning word width per lane.
REQ-002 SHALL have parameter DEPTH, default 16, meaning maximum k-steps buffered per tile.
REQ-003 SHALL have parameter DRAIN_CYC, default 6, meaning zero-fill cycles after last skewed beat.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-high (1 = reset).
REQ-006 wr_en  input  1  buffer write strobe.
REQ-007 wr_addr  input  log2(DEPTH)  k-step index written.
REQ-008 wr_data  input  4*DW  data words for rows 0..3; lane i = bits [i*DW +: DW].
REQ-009 wr_weight  input  4*DW  weight words for columns 0..3; same lane packing.
REQ-010 start  input  1  one-cycle tile start request.
REQ-011 len  input  log2(DEPTH)+1  k-steps in tile, sampled with start.
REQ-012 busy  output  1  high from the cycle after accepted start until done.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 data0_out..data3_out  output  DW each  skewed row data to PE array data inputs.
REQ-015 weight0_out..weight3_out  output  DW each  skewed column weights to PE array weight inputs.
REQ-016 feed_valid  output  1  high while any lane carries a buffered (non-fill) word.

Function
REQ-017 SHALL hold DEPTH entries of {wr_data, wr_weight}; wr_en writes entry wr_addr at clock edge when busy=0; writes while busy=1 are dropped.
REQ-018 SHALL implement FSM IDLE -> FEED -> DRAIN -> IDLE; done asserts on the DRAIN->IDLE transition cycle.
REQ-019 In IDLE, start=1 with 1<=len<=DEPTH SHALL latch len and enter FEED; len>DEPTH SHALL be clamped to DEPTH.
REQ-020 start with len=0 SHALL skip FEED/DRAIN: done pulses the next cycle, busy stays 0, outputs stay 0.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 With t=0 the first cycle after accepted start, lane i outputs (data_i_out, weight_i_out) SHALL equal entry (t-i) when 0<=t-i<len, else 0.
REQ-023 FEED SHALL last len+3 cycles (t=0..len+2); DRAIN SHALL last DRAIN_CYC cycles of all-zero outputs.
REQ-024 done SHALL be high exactly at t=len+3+DRAIN_CYC, with busy low in that cycle and after; busy high for t=0..len+2+DRAIN_CYC.
REQ-025 feed_valid SHALL be high for t=0..len+2, low otherwise.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-027 Writes to an entry in the cycle start is accepted SHALL be visible to the tile (write-before-read).
REQ-028 Back-to-back tiles: start in the done cycle SHALL be accepted, next t=0 one cycle later.

Reset
REQ-029 rst_n=1 SHALL force IDLE, busy=0, done=0, feed_valid=0, all data/weight outputs 0 at next edge, including mid-FEED/DRAIN.
REQ-030 Reset SHALL NOT be required to clear buffer contents; entries retain last written value.
REQ-031 After reset deassertion, first start SHALL be accepted the same cycle it is presented.

Verification
REQ-032 Write entries k=0..3 with data lane i = 16*k+i, weight lane i = 256+16*k+i; start len=4 -> t=0 data0=0x00, t=1 data0=0x10 data1=0x01, t=3 data3=0x03 weight3=0x103, t=6 data3=0x33, t=7..12 all zero, done at t=13.
REQ-033 start len=0 -> done one cycle later, busy never high, outputs 0.
REQ-034 start len=20 (DEPTH=16) -> 16 beats fed, done at t=16+3+6=25.
REQ-035 Assert rst_n at t=5 of len=8 tile -> next cycle all outputs 0, busy=0, no done; new start len=2 completes with done at t=11.
REQ-036 wr_en to entry 0 with value 0xAAAA during busy -> dropped; next tile reads prior value; start asserted again during busy -> ignored, single done.
REQ-037 start in done cycle of tile 1 (len=1) -> tile 2 t=0 on following cycle, no gap beyond that cycle, two done pulses 10 cycles apart.
